// File: rtl/uart_apb_pkg.sv
// Shared types and constants for the UART APB requester: FSM encoding,
// UART register map and default bus widths.
package uart_apb_pkg;

    localparam int unsigned DEF_ADDR_W = 2;
    localparam int unsigned DEF_DATA_W = 8;

    typedef enum logic [1:0] {
        StIdle   = 2'b00,
        StSetup  = 2'b01,
        StAccess = 2'b10
    } apb_state_e;

    localparam logic [1:0] REG_DATA = 2'b00;
    localparam logic [1:0] REG_BAUD = 2'b01;
    localparam logic [1:0] REG_CTRL = 2'b10;
    localparam logic [1:0] REG_STAT = 2'b11;

endpackage

// File: rtl/apb_wait_timer.sv
// Counts ACCESS-phase wait states and flags the cycle on which the transfer
// must be aborted. Only instantiated when APB_TIMEOUT_EN is defined.
module apb_wait_timer #(
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic access_i,
    input  logic pready_i,
    output logic expire_o
);

    logic [7:0] wait_cnt_q, wait_cnt_d;

    // Held at zero outside ACCESS, so every ACCESS entry starts from 0.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (!access_i) begin
            wait_cnt_d = '0;
        end else if (!pready_i) begin
            wait_cnt_d = wait_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign expire_o = access_i && !pready_i && (wait_cnt_q == 8'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/apb_uart_master.sv
// APB3 requester for the UART register port: one command at a time in,
// SETUP/ACCESS sequencing, one-cycle response pulse out.
// Define APB_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYC wait cycles.
module apb_uart_master
    import uart_apb_pkg::*;
#(
    parameter int unsigned ADDR_W      = DEF_ADDR_W,
    parameter int unsigned DATA_W      = DEF_DATA_W,
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic              PCLK,
    input  logic              PRESETN,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_timeout,
    output logic              busy,
    output logic              PSEL,
    output logic              PENABLE,
    output logic [ADDR_W-1:0] PADDR,
    output logic              PWRITE,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY
);

    if (TIMEOUT_CYC < 2 || TIMEOUT_CYC > 255) begin : g_bad_timeout
        $error("apb_uart_master: TIMEOUT_CYC must be in 2..255");
    end

    apb_state_e        state_q, state_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic              pwrite_q, pwrite_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_timeout_q, rsp_timeout_d;
    logic              expire;

`ifdef APB_TIMEOUT_EN
    apb_wait_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_wait_timer (
        .clk_i    (PCLK),
        .rst_ni   (PRESETN),
        .access_i (state_q == StAccess),
        .pready_i (PREADY),
        .expire_o (expire)
    );
`else
    assign expire = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        paddr_d       = paddr_q;
        pwrite_d      = pwrite_q;
        pwdata_d      = pwdata_q;
        rsp_valid_d   = 1'b0;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_timeout_d = rsp_timeout_q;
        unique case (state_q)
            StIdle: begin
                if (cmd_valid && cmd_ready_q) begin
                    paddr_d  = cmd_addr;
                    pwrite_d = cmd_write;
                    pwdata_d = cmd_write ? cmd_wdata : '0;
                    state_d  = StSetup;
                end
            end
            StSetup: state_d = StAccess;
            StAccess: begin
                // PREADY is checked first so a completion on the expiry cycle wins.
                if (PREADY) begin
                    state_d       = StIdle;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = pwrite_q ? '0 : PRDATA;
                    rsp_timeout_d = 1'b0;
                end else if (expire) begin
                    state_d       = StIdle;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = '0;
                    rsp_timeout_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
        // Registered so cmd_ready reads 0 during reset and rises on the first edge after.
        cmd_ready_d = (state_d == StIdle);
    end

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            state_q       <= StIdle;
            cmd_ready_q   <= 1'b0;
            paddr_q       <= '0;
            pwrite_q      <= 1'b0;
            pwdata_q      <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cmd_ready_q   <= cmd_ready_d;
            paddr_q       <= paddr_d;
            pwrite_q      <= pwrite_d;
            pwdata_q      <= pwdata_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign busy        = (state_q != StIdle);
    assign PSEL        = (state_q != StIdle);
    assign PENABLE     = (state_q == StAccess);
    assign PADDR       = paddr_q;
    assign PWRITE      = pwrite_q;
    assign PWDATA      = pwdata_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_uart_master.sv
// Directed bench for apb_uart_master; expected responses are queued at issue
// and matched when rsp_valid pulses. Timeout steps need APB_TIMEOUT_EN.
module tb_apb_uart_master;
    import uart_apb_pkg::*;

    localparam int unsigned ADDR_W = 2;
    localparam int unsigned DATA_W = 8;

    logic              PCLK = 1'b0;
    logic              PRESETN = 1'b1;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic              cmd_write = 1'b0;
    logic [ADDR_W-1:0] cmd_addr = '0;
    logic [DATA_W-1:0] cmd_wdata = '0;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_timeout;
    logic              busy;
    logic              PSEL;
    logic              PENABLE;
    logic [ADDR_W-1:0] PADDR;
    logic              PWRITE;
    logic [DATA_W-1:0] PWDATA;
    logic [DATA_W-1:0] PRDATA = '0;
    logic              PREADY = 1'b0;

    typedef struct packed {
        logic [DATA_W-1:0] rdata;
        logic              tmo;
    } rsp_t;

    rsp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    apb_uart_master #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .TIMEOUT_CYC (16)
    ) dut (
        .PCLK        (PCLK),
        .PRESETN     (PRESETN),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_timeout (rsp_timeout),
        .busy        (busy),
        .PSEL        (PSEL),
        .PENABLE     (PENABLE),
        .PADDR       (PADDR),
        .PWRITE      (PWRITE),
        .PWDATA      (PWDATA),
        .PRDATA      (PRDATA),
        .PREADY      (PREADY)
    );

    always #5 PCLK = ~PCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge PCLK);
        #1;
    endtask

    // Scoreboard: every rsp_valid must match the oldest outstanding expectation.
    always @(negedge PCLK) begin
        if (PRESETN === 1'b1 && rsp_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rsp", 32'(rsp_valid), 32'd0);
            end else begin
                rsp_t e;
                e = exp_q.pop_front();
                chk("sb_rdata", 32'(rsp_rdata), 32'(e.rdata));
                chk("sb_timeout", 32'(rsp_timeout), 32'(e.tmo));
            end
        end
    end

    initial begin
        rsp_t e;

        // Reset held for 3 cycles
        #2 PRESETN = 1'b0;
        repeat (3) @(posedge PCLK);
        #1;
        chk("rst_psel", 32'(PSEL), 32'd0);
        chk("rst_penable", 32'(PENABLE), 32'd0);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_paddr", 32'(PADDR), 32'd0);
        chk("rst_pwdata", 32'(PWDATA), 32'd0);
        chk("rst_rdata", 32'(rsp_rdata), 32'd0);
        PRESETN = 1'b1;
        step();
        chk("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);

        // Zero-wait write to REG_BAUD
        PREADY = 1'b1;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = REG_BAUD; cmd_wdata = 8'h1A;
        e.rdata = '0; e.tmo = 1'b0; exp_q.push_back(e);
        step();
        cmd_valid = 1'b0;
        chk("wr_c1_psel", 32'(PSEL), 32'd1);
        chk("wr_c1_penable", 32'(PENABLE), 32'd0);
        chk("wr_c1_paddr", 32'(PADDR), 32'h1);
        chk("wr_c1_pwdata", 32'(PWDATA), 32'h1A);
        chk("wr_c1_pwrite", 32'(PWRITE), 32'd1);
        chk("wr_c1_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("wr_c1_busy", 32'(busy), 32'd1);
        step();
        chk("wr_c2_penable", 32'(PENABLE), 32'd1);
        chk("wr_c2_psel", 32'(PSEL), 32'd1);
        step();
        chk("wr_c3_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("wr_c3_rdata", 32'(rsp_rdata), 32'd0);
        chk("wr_c3_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("wr_c3_psel", 32'(PSEL), 32'd0);
        chk("wr_c3_paddr_hold", 32'(PADDR), 32'h1);

        // Read REG_DATA with 4 wait states; wdata must not leak onto PWDATA
        PREADY = 1'b0; PRDATA = 8'h00;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = REG_DATA; cmd_wdata = 8'hFF;
        e.rdata = 8'hC3; e.tmo = 1'b0; exp_q.push_back(e);
        step();
        cmd_valid = 1'b0;
        chk("rd_c1_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rd_c1_pwdata", 32'(PWDATA), 32'd0);
        chk("rd_c1_pwrite", 32'(PWRITE), 32'd0);
        step();
        for (int i = 0; i < 5; i++) begin
            chk("rd_acc_penable", 32'(PENABLE), 32'd1);
            chk("rd_acc_psel", 32'(PSEL), 32'd1);
            chk("rd_acc_paddr", 32'(PADDR), 32'd0);
            chk("rd_acc_pwrite", 32'(PWRITE), 32'd0);
            chk("rd_acc_rsp_valid", 32'(rsp_valid), 32'd0);
            if (i == 4) begin
                PREADY = 1'b1; PRDATA = 8'hC3;
            end
            step();
        end
        chk("rd_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("rd_rdata", 32'(rsp_rdata), 32'hC3);
        PRDATA = 8'h00;
        step();
        chk("rd_rsp_one_cycle", 32'(rsp_valid), 32'd0);
        chk("rd_rdata_hold", 32'(rsp_rdata), 32'hC3);

        // Back-to-back writes with cmd_valid held high
        PREADY = 1'b1;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = REG_CTRL; cmd_wdata = 8'h55;
        e.rdata = '0; e.tmo = 1'b0; exp_q.push_back(e);
        step();
        cmd_addr = REG_STAT; cmd_wdata = 8'hAA;
        chk("b2b_c1_paddr", 32'(PADDR), 32'h2);
        chk("b2b_c1_cmd_ready", 32'(cmd_ready), 32'd0);
        step();
        chk("b2b_c2_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("b2b_c2_pwdata", 32'(PWDATA), 32'h55);
        step();
        chk("b2b_c3_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("b2b_c3_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("b2b_c3_psel_gap", 32'(PSEL), 32'd0);
        e.rdata = '0; e.tmo = 1'b0; exp_q.push_back(e);
        step();
        cmd_valid = 1'b0;
        chk("b2b_c4_psel", 32'(PSEL), 32'd1);
        chk("b2b_c4_penable", 32'(PENABLE), 32'd0);
        chk("b2b_c4_paddr", 32'(PADDR), 32'h3);
        chk("b2b_c4_pwdata", 32'(PWDATA), 32'hAA);
        step();
        step();
        chk("b2b_c6_rsp_valid", 32'(rsp_valid), 32'd1);

`ifdef APB_TIMEOUT_EN
        // Abort after 16 ACCESS cycles with PREADY held low
        PREADY = 1'b0; PRDATA = 8'h77;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = REG_STAT;
        e.rdata = '0; e.tmo = 1'b1; exp_q.push_back(e);
        step();
        cmd_valid = 1'b0;
        step();
        for (int i = 0; i < 16; i++) begin
            chk("tmo_acc_penable", 32'(PENABLE), 32'd1);
            step();
        end
        chk("tmo_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("tmo_flag", 32'(rsp_timeout), 32'd1);
        chk("tmo_rdata", 32'(rsp_rdata), 32'd0);
        chk("tmo_psel", 32'(PSEL), 32'd0);
        chk("tmo_penable", 32'(PENABLE), 32'd0);

        // PREADY on the would-be-timeout cycle completes normally
        PRDATA = 8'h5A;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = REG_STAT;
        e.rdata = 8'h5A; e.tmo = 1'b0; exp_q.push_back(e);
        step();
        cmd_valid = 1'b0;
        step();
        for (int i = 0; i < 16; i++) begin
            chk("tmo2_acc_penable", 32'(PENABLE), 32'd1);
            if (i == 15) PREADY = 1'b1;
            step();
        end
        chk("tmo2_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("tmo2_flag", 32'(rsp_timeout), 32'd0);
        chk("tmo2_rdata", 32'(rsp_rdata), 32'h5A);
        PREADY = 1'b0;
        step();
`endif

        // Reset in the middle of a waited read: no response may appear
        PREADY = 1'b0;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = REG_DATA;
        step();
        cmd_valid = 1'b0;
        step();
        step();
        chk("mid_pre_penable", 32'(PENABLE), 32'd1);
        #2 PRESETN = 1'b0;
        #1;
        chk("mid_rst_psel", 32'(PSEL), 32'd0);
        chk("mid_rst_penable", 32'(PENABLE), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        step();
        step();
        PRESETN = 1'b1;
        step();
        chk("mid_post_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("mid_post_rsp_valid", 32'(rsp_valid), 32'd0);
        step();
        chk("mid_post_psel", 32'(PSEL), 32'd0);

        repeat (3) step();
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/apb_uart_master.md
Name: apb_uart_master

Overview:
- APB3 requester that drives the UART's APB slave port (PSEL/PENABLE/PADDR/PWRITE/PWDATA out; PRDATA/PREADY in).
- Accepts single read/write commands on a valid/ready command port, sequences the APB SETUP and ACCESS phases, and returns read data or completion on a one-cycle response pulse.
- Sits between a local controller (test sequencer or CPU-side bridge) and the UART core's register interface.

Parameters:
- ADDR_W, 2, APB address width; matches the UART register map.
- DATA_W, 8, APB data width; matches BITWIDTH.
- TIMEOUT_CYC, 16, ACCESS-phase cycles with PREADY low before abort. Used only with APB_TIMEOUT_EN; legal range 2..255.

Ports:
- PCLK  in  1  clock; all logic on the rising edge.
- PRESETN  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  register address.
- cmd_wdata  in  DATA_W  write data.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  DATA_W  captured PRDATA for reads; 0 for writes.
- rsp_timeout  out  1  qualifies rsp_valid; transfer was aborted.
- busy  out  1  transfer in progress (state != IDLE).
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PADDR  out  ADDR_W  APB address.
- PWRITE  out  1  APB direction.
- PWDATA  out  DATA_W  APB write data.
- PRDATA  in  DATA_W  APB read data.
- PREADY  in  1  APB ready.

Behaviour:
- Clock and reset: one clock, PCLK; reset is asynchronous and active-low on PRESETN.
- Reset values: all outputs 0, state = IDLE, internal counters 0. Asserting PRESETN mid-transfer drops PSEL/PENABLE immediately, with no response issued.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - cmd_ready = 1.
  - On handshake, register cmd_addr/cmd_write/cmd_wdata into PADDR/PWRITE/PWDATA (PWDATA = 0 for reads) and go to SETUP.
- SETUP: PSEL = 1, PENABLE = 0; exactly one cycle, then ACCESS.
- ACCESS:
  - PSEL = 1, PENABLE = 1.
  - If PREADY = 1: capture PRDATA into rsp_rdata (reads only), pulse rsp_valid for the next cycle, go to IDLE.
  - If PREADY = 0: hold in ACCESS.
- cmd_ready = 0 in SETUP and ACCESS. A cmd_valid presented then is held off, never dropped.
- PADDR/PWRITE/PWDATA stay stable from SETUP through the final ACCESS cycle. They keep their last values in IDLE; PSEL = 0 there.
- Latency:
  - Handshake at cycle 0; SETUP at cycle 1; ACCESS from cycle 2.
  - With zero-wait PREADY, rsp_valid is high at cycle 3, and cmd_ready is also high at cycle 3.
  - Minimum issue interval is 3 cycles.
- rsp_valid has no backpressure. It is high exactly one cycle per completed or aborted transfer.
- rsp_rdata and rsp_timeout hold their values until the next response.
- busy = (state != IDLE).

Optional Feature:
- Macro: APB_TIMEOUT_EN.
- Defined:
  - An 8-bit wait_cnt clears on entry to ACCESS and increments each ACCESS cycle with PREADY = 0.
  - When PREADY = 0 and wait_cnt == TIMEOUT_CYC-1: abort. Next cycle PSEL = PENABLE = 0, state = IDLE, rsp_valid = 1, rsp_timeout = 1, rsp_rdata = 0.
  - PREADY = 1 on the would-be-timeout cycle is a normal completion (completion wins).
- Undefined: no counter; ACCESS waits indefinitely; rsp_timeout tied 0.

Decomposition:
- Shared package uart_apb_pkg holds:
  - FSM state enum: IDLE = 2'b00, SETUP = 2'b01, ACCESS = 2'b10.
  - UART register address constants: REG_DATA = 2'b00, REG_BAUD = 2'b01, REG_CTRL = 2'b10, REG_STAT = 2'b11.
  - Default DATA_W and ADDR_W.
- One natural sub-module: apb_wait_timer (wait_cnt plus compare, outputs expire). Instantiated only under APB_TIMEOUT_EN.

Test Plan:
- Reset: PRESETN low for 3 cycles, deassert -> all outputs 0, cmd_ready = 1 on the first cycle after release.
- Zero-wait write: cmd write addr 2'b01 data 8'h1A, PREADY tied 1.
  - Cycle 1: PSEL = 1, PENABLE = 0, PADDR = 01, PWDATA = 1A.
  - Cycle 2: PENABLE = 1.
  - Cycle 3: rsp_valid = 1, rsp_rdata = 0.
- Wait-state read: cmd read addr 2'b00, PREADY low for 4 ACCESS cycles then high with PRDATA = 8'hC3 -> ACCESS lasts 5 cycles, signals stable throughout, rsp_rdata = C3, rsp_valid exactly one cycle.
- Back-to-back: cmd_valid held high with two writes -> second handshake only at the cmd_ready cycle after the first rsp_valid; PSEL drops for exactly one IDLE cycle between transfers.
- Timeout (APB_TIMEOUT_EN, TIMEOUT_CYC = 16): PREADY held 0 -> abort after 16 ACCESS cycles, rsp_timeout = 1, rsp_rdata = 0, PSEL = 0. Repeat with PREADY = 1 on the 16th cycle -> normal completion, rsp_timeout = 0.
- Reset mid-ACCESS: assert PRESETN during a waited read -> PSEL/PENABLE = 0 asynchronously, no rsp_valid, cmd_ready = 1 after release.
